// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master arbiter for the shared memory-mapped peripheral bus.
// Build option: define ARB_FIXED_PRIO_EN for fixed master-0 priority instead of round-robin.
module periph_bus_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_rd,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_rd,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,

  output logic          s_rd,
  output logic          s_wr,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  // lock_cnt counts extra accesses already granted; reaching this value forces release
  localparam logic [3:0] LOCK_LAST = 4'(MAX_LOCK - 1);

  state_t        state, state_next;
  logic          owner, owner_next;
  logic          rr_last, rr_last_next;
  logic [3:0]    lock_cnt, lock_cnt_next;
  logic [DW-1:0] m0_rdata_q, m1_rdata_q;

  logic          own_req;
  logic          own_lock;
  logic          own_rd;
  logic          own_wr;
  logic [AW-1:0] own_addr;
  logic [DW-1:0] own_wdata;
  logic          winner;
  logic [DW-1:0] capture;

  always_comb begin
    own_req   = owner ? m1_req   : m0_req;
    own_lock  = owner ? m1_lock  : m0_lock;
    own_rd    = owner ? m1_rd    : m0_rd;
    own_wr    = owner ? m1_wr    : m0_wr;
    own_addr  = owner ? m1_addr  : m0_addr;
    own_wdata = owner ? m1_wdata : m0_wdata;
  end

  // Only meaningful when at least one master is requesting
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner = ~m0_req;
`else
    winner = (m0_req && m1_req) ? ~rr_last : m1_req;
`endif
  end

  always_comb begin
    state_next    = state;
    owner_next    = owner;
    rr_last_next  = rr_last;
    lock_cnt_next = lock_cnt;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          owner_next = winner;
          state_next = ACC;
        end
      end
      ACC: begin
        state_next = RSP;
      end
      RSP: begin
        if (own_req && own_lock && (lock_cnt < LOCK_LAST)) begin
          lock_cnt_next = lock_cnt + 4'd1;
          state_next    = ACC;
        end else begin
          rr_last_next  = owner;
          lock_cnt_next = 4'd0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Slave side is driven only during the single ACC cycle; write wins over read
  always_comb begin
    s_rd    = 1'b0;
    s_wr    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (state == ACC) begin
      s_wr    = own_wr;
      s_rd    = own_rd & ~own_wr;
      s_addr  = own_addr;
      s_wdata = own_wdata;
    end
  end

  assign capture = s_rd ? s_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rr_last  <= 1'b1;
      lock_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      owner    <= owner_next;
      rr_last  <= rr_last_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Read data is latched at the end of ACC and held until that master's next access
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else if (state == ACC) begin
      if (owner) begin
        m1_rdata_q <= capture;
      end else begin
        m0_rdata_q <= capture;
      end
    end
  end

  assign m0_gnt   = ((state == ACC) || (state == RSP)) && !owner;
  assign m1_gnt   = ((state == ACC) || (state == RSP)) &&  owner;
  assign m0_done  = (state == RSP) && !owner;
  assign m1_done  = (state == RSP) &&  owner;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: scoreboard bench for periph_bus_arbiter (strobes and done pulses
// are matched against expectations queued when each access is requested).
module tb_periph_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m0_lock, m0_rd, m0_wr;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_done;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_lock, m1_rd, m1_wr;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_done;
  logic [DW-1:0] m1_rdata;
  logic          s_rd, s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit            master;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } stb_t;

  typedef struct {
    bit            master;
    logic [DW-1:0] rdata;
  } done_t;

  stb_t  stb_q[$];
  done_t done_q[$];

  always #5 clk = ~clk;

  periph_bus_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_lock  (m0_lock),
    .m0_rd    (m0_rd),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_done  (m0_done),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_lock  (m1_lock),
    .m1_rd    (m1_rd),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_done  (m1_done),
    .m1_rdata (m1_rdata),
    .s_rd     (s_rd),
    .s_wr     (s_wr),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata)
  );

  // Slave register model: fixed pattern per address
  function automatic logic [DW-1:0] rdata_fn(input logic [AW-1:0] a);
    return (a == 32'h4000_0010) ? 32'h0000_00A5 : {a[15:0], ~a[15:0]};
  endfunction

  assign s_rdata = rdata_fn(s_addr);

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit m, input logic req, input logic lock, input logic rd,
                               input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (m) begin
      m1_req = req; m1_lock = lock; m1_rd = rd; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_lock = lock; m0_rd = rd; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic expectAccess(input bit m, input logic rd, input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input bit completes);
    stb_t  s;
    done_t d;
    if (rd || wr) begin
      s.master = m; s.wr = wr; s.addr = addr; s.wdata = wdata;
      stb_q.push_back(s);
    end
    if (completes) begin
      d.master = m;
      d.rdata  = wr ? 32'h0 : (rd ? rdata_fn(addr) : 32'h0);
      done_q.push_back(d);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    applyStimulus(1'b1, 0, 0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", {m0_gnt, m1_gnt}, 0);
    checkOutput("rst_done", {m0_done, m1_done}, 0);
    checkOutput("rst_m0_rdata", m0_rdata, 0);
    checkOutput("rst_m1_rdata", m1_rdata, 0);
    checkOutput("rst_strobe", {s_rd, s_wr}, 0);
    checkOutput("rst_s_addr", s_addr, 0);
    checkOutput("rst_s_wdata", s_wdata, 0);
    #1 reset = 1'b0;
  endtask

  // Bus monitor: invariants every cycle, scoreboard match on strobes and done pulses
  always @(negedge clk) begin
    stb_t  es;
    done_t ed;
    checkOutput("gnt_excl", 64'(m0_gnt & m1_gnt), 0);
    checkOutput("done_excl", 64'(m0_done & m1_done), 0);
    checkOutput("stb_has_owner", 64'((s_rd | s_wr) & ~(m0_gnt | m1_gnt)), 0);
    if (s_rd || s_wr) begin
      checkOutput("stb_expected", 64'(stb_q.size() != 0), 1);
      if (stb_q.size() != 0) begin
        es = stb_q.pop_front();
        checkOutput("stb_owner", m1_gnt, es.master);
        checkOutput("stb_wr", s_wr, es.wr);
        checkOutput("stb_rd", s_rd, !es.wr);
        checkOutput("stb_addr", s_addr, es.addr);
        if (es.wr) checkOutput("stb_wdata", s_wdata, es.wdata);
      end
    end
    if (m0_done || m1_done) begin
      checkOutput("done_expected", 64'(done_q.size() != 0), 1);
      if (done_q.size() != 0) begin
        ed = done_q.pop_front();
        checkOutput("done_master", m1_done, ed.master);
        checkOutput("done_rdata", ed.master ? m1_rdata : m0_rdata, ed.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  slot, phase, k, d0, c;
    int  d1[6];
    bit  served, busy, got0, got1;

    // Single m0 read with cycle-exact latency
    resetDut();
    expectAccess(1'b0, 1, 0, 32'h4000_0010, '0, 1'b1);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h4000_0010, '0);
    @(negedge clk);
    checkOutput("t1_s_rd", s_rd, 1);
    checkOutput("t1_m0_gnt", m0_gnt, 1);
    checkOutput("t1_s_addr", s_addr, 32'h4000_0010);
    @(negedge clk);
    checkOutput("t1_m0_done", m0_done, 1);
    checkOutput("t1_m0_rdata", m0_rdata, 32'h0000_00A5);
    checkOutput("t1_m1_quiet", {m1_gnt, m1_done, m1_rdata}, 0);
    #1 applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t1_idle_gnt", m0_gnt, 0);
    checkOutput("t1_rdata_hold", m0_rdata, 32'h0000_00A5);

    // Simultaneous writes, both masters keep requesting
    resetDut();
    for (int i = 0; i < 4; i++) begin
      served = FIXED ? 1'b0 : i[0];
      expectAccess(served, 0, 1, served ? 32'h4000_0008 : 32'h4000_0004,
                   served ? 32'h2222_0000 : 32'h1111_0000, 1'b1);
    end
    applyStimulus(1'b0, 1, 0, 0, 1, 32'h4000_0004, 32'h1111_0000);
    applyStimulus(1'b1, 1, 0, 0, 1, 32'h4000_0008, 32'h2222_0000);
    for (int i = 1; i <= 11; i++) begin
      slot   = (i - 1) / 3;
      phase  = (i - 1) % 3;
      busy   = (phase != 2);
      served = FIXED ? 1'b0 : slot[0];
      @(negedge clk);
      checkOutput($sformatf("t2_m0_gnt_c%0d", i), m0_gnt, busy && !served);
      checkOutput($sformatf("t2_m1_gnt_c%0d", i), m1_gnt, busy && served);
      checkOutput($sformatf("t2_s_wr_c%0d", i), s_wr, phase == 0);
    end
    #1;
    applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    applyStimulus(1'b1, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;

    // m1 locked burst of 6 reads, m0 requests one read during the burst
    for (int i = 0; i < 4; i++) expectAccess(1'b1, 1, 0, 32'h4000_0020 + 32'(4 * i), '0, 1'b1);
    expectAccess(1'b0, 1, 0, 32'h4000_0100, '0, 1'b1);
    for (int i = 4; i < 6; i++) expectAccess(1'b1, 1, 0, 32'h4000_0020 + 32'(4 * i), '0, 1'b1);
    k  = 0;
    d0 = -1;
    for (int i = 0; i < 6; i++) d1[i] = -1;
    applyStimulus(1'b1, 1, 1, 1, 0, 32'h4000_0020, '0);
    c = 0;
    while (c < 40 && k < 6) begin
      c++;
      @(negedge clk);
      got0 = m0_done;
      got1 = m1_done;
      if (got1) begin
        d1[k] = c;
        k++;
      end
      if (got0) d0 = c;
      #1;
      if (c == 1) applyStimulus(1'b0, 1, 0, 1, 0, 32'h4000_0100, '0);
      if (got0) applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
      if (got1) begin
        if (k < 6) m1_addr = 32'h4000_0020 + 32'(4 * k);
        else applyStimulus(1'b1, 0, 0, 0, 0, '0, '0);
      end
    end
    applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    applyStimulus(1'b1, 0, 0, 0, 0, '0, '0);
    checkOutput("t3_m1_count", k, 6);
    checkOutput("t3_first_done", d1[0], 2);
    for (int i = 1; i < 4; i++) checkOutput($sformatf("t3_lock_gap%0d", i), d1[i] - d1[i-1], 2);
    checkOutput("t3_m0_slot", d0, d1[3] + 3);
    checkOutput("t3_m1_resume", d1[4], d0 + 3);
    checkOutput("t3_m1_relock", d1[5], d1[4] + 2);
    @(negedge clk);
    #1;

    // Read+write collapses to write; then a read; then a no-op access
    expectAccess(1'b0, 1, 1, 32'h4000_000C, 32'h0000_003C, 1'b1);
    applyStimulus(1'b0, 1, 0, 1, 1, 32'h4000_000C, 32'h0000_003C);
    @(negedge clk);
    checkOutput("t4_s_wr", s_wr, 1);
    checkOutput("t4_s_rd", s_rd, 0);
    checkOutput("t4_s_wdata", s_wdata, 32'h0000_003C);
    @(negedge clk);
    checkOutput("t4_done", m0_done, 1);
    checkOutput("t4_rdata_zero", m0_rdata, 0);
    #1 applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;
    expectAccess(1'b0, 1, 0, 32'h4000_0010, '0, 1'b1);
    applyStimulus(1'b0, 1, 0, 1, 0, 32'h4000_0010, '0);
    repeat (2) @(negedge clk);
    #1 applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;
    expectAccess(1'b0, 0, 0, 32'h4000_0014, '0, 1'b1);
    applyStimulus(1'b0, 1, 0, 0, 0, 32'h4000_0014, '0);
    @(negedge clk);
    checkOutput("t4_noop_strobe", {s_rd, s_wr}, 0);
    checkOutput("t4_noop_gnt", m0_gnt, 1);
    @(negedge clk);
    checkOutput("t4_noop_done", m0_done, 1);
    checkOutput("t4_noop_rdata", m0_rdata, 0);
    #1 applyStimulus(1'b0, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;

    // Reset during the ACC cycle of an m1 write
    expectAccess(1'b1, 0, 1, 32'h4000_0018, 32'h0000_DEAD, 1'b0);
    applyStimulus(1'b1, 1, 0, 0, 1, 32'h4000_0018, 32'h0000_DEAD);
    @(negedge clk);
    checkOutput("t5_s_wr", s_wr, 1);
    checkOutput("t5_m1_gnt", m1_gnt, 1);
    #1;
    reset = 1'b1;
    applyStimulus(1'b1, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checkOutput("t5_gnt", {m0_gnt, m1_gnt}, 0);
    checkOutput("t5_done", {m0_done, m1_done}, 0);
    checkOutput("t5_strobe", {s_rd, s_wr}, 0);
    checkOutput("t5_m1_rdata", m1_rdata, 0);
    checkOutput("t5_s_addr", s_addr, 0);
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("sb_stb_left", stb_q.size(), 0);
    checkOutput("sb_done_left", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
